// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: conditions the raw clock/data lines, deserialises
// device-to-host frames and turns extended arrow make codes into command pulses.
module ps2_key_decoder #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       left,
    output logic       right,
    output logic       down,
    output logic       ro,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_clk_sync;
    logic [1:0]      r_dat_sync;
    logic            r_filt_clk;
    logic            r_filt_prev;
    logic [FW-1:0]   r_filt_cnt;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic            r_par_ok;
    logic            r_ext;
    logic            r_brk;
    logic [3:0]      r_cmd;
    logic [7:0]      r_scan_code;
    logic            r_scan_valid;
    logic            r_frame_err;

    logic            w_clk_s;
    logic            w_dat_s;
    logic            w_strobe;
    logic            w_timeout;
    logic            w_stop_evt;
    logic            w_good;
    logic            w_err;
    logic [3:0]      w_cmd;

    // Lines idle high, so the synchronisers start high to avoid a false edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
        end
    end

    assign w_clk_s = r_clk_sync[1];
    assign w_dat_s = r_dat_sync[1];

    // Filtered clock only follows after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filt_clk  <= 1'b1;
            r_filt_prev <= 1'b1;
            r_filt_cnt  <= '0;
        end else begin
            r_filt_prev <= r_filt_clk;
            if (w_clk_s == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_filt_clk <= w_clk_s;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_strobe  = r_filt_prev & ~r_filt_clk;
    assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TW'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = ST_IDLE;
        end else if (w_strobe) begin
            case (r_state)
                ST_IDLE:   if (!w_dat_s) w_next = ST_DATA;
                ST_DATA:   if (r_bit_cnt == 3'd7) w_next = ST_PARITY;
                ST_PARITY: w_next = ST_STOP;
                ST_STOP:   w_next = ST_IDLE;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_stop_evt = (r_state == ST_STOP) && w_strobe && !w_timeout;
        w_good     = w_stop_evt && w_dat_s && r_par_ok;
        w_err      = w_timeout || (w_stop_evt && !(w_dat_s && r_par_ok));
        w_cmd      = '0;
        if (w_good && r_ext && !r_brk) begin
            case (r_shift)
                8'h6B:   w_cmd = 4'b1000;
                8'h74:   w_cmd = 4'b0100;
                8'h72:   w_cmd = 4'b0010;
                8'h75:   w_cmd = 4'b0001;
                default: w_cmd = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_to_cnt     <= '0;
            r_par_ok     <= 1'b0;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_cmd        <= '0;
            r_scan_code  <= '0;
            r_scan_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_scan_valid <= w_good;
            r_frame_err  <= w_err;
            r_cmd        <= w_cmd;
            if (w_good) r_scan_code <= r_shift;

            if (r_state == ST_IDLE || w_strobe || w_timeout) r_to_cnt <= '0;
            else                                             r_to_cnt <= r_to_cnt + 1'b1;

            if (w_strobe && !w_timeout) begin
                case (r_state)
                    ST_IDLE:   r_bit_cnt <= '0;
                    ST_DATA: begin
                        r_shift   <= {w_dat_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    ST_PARITY: r_par_ok <= ^{r_shift, w_dat_s};
                    default:   ;
                endcase
            end

            if (w_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_good) begin
                if (r_shift == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
        end
    end

    assign left       = r_cmd[3];
    assign right      = r_cmd[2];
    assign down       = r_cmd[1];
    assign ro         = r_cmd[0];
    assign scan_code  = r_scan_code;
    assign scan_valid = r_scan_valid;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: a keyboard model drives frames, a
// prefix-history reference model predicts each output event.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

    localparam int HALF = 25;
    localparam int TO   = 500;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       left, right, down, ro;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic [3:0] cmd;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] pend_q[$];
    logic [7:0] last_code = 8'h00;
    int         checks = 0;
    int         errors = 0;

    always #10 clk = ~clk;

    ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT(TO)) u_dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .left(left), .right(right), .down(down), .ro(ro),
        .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] arrow(input logic [7:0] b);
        case (b)
            8'h6B:   return 4'b1000;
            8'h74:   return 4'b0100;
            8'h72:   return 4'b0010;
            8'h75:   return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    // A command fires only if the prefixes since the last code include E0 but no F0.
    task automatic model_good(input logic [7:0] b);
        ev_t e;
        bit  saw_e0, saw_f0;
        saw_e0 = 0; saw_f0 = 0;
        foreach (pend_q[k]) begin
            if (pend_q[k] == 8'hE0) saw_e0 = 1;
            if (pend_q[k] == 8'hF0) saw_f0 = 1;
        end
        e.is_err = 0; e.code = b; e.cmd = 4'b0000;
        if (b == 8'hE0 || b == 8'hF0) begin
            pend_q.push_back(b);
        end else begin
            if (saw_e0 && !saw_f0) e.cmd = arrow(b);
            pend_q.delete();
        end
        last_code = b;
        exp_q.push_back(e);
    endtask

    task automatic model_err();
        ev_t e;
        pend_q.delete();
        e.is_err = 1; e.code = last_code; e.cmd = 4'b0000;
        exp_q.push_back(e);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int nbits, input int glitch_bit);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            if (i == glitch_bit) begin
                wait_clk(12); ps2_clk = 1'b0;
                wait_clk(3);  ps2_clk = 1'b1;
                wait_clk(HALF - 15);
            end else begin
                wait_clk(HALF);
            end
            ps2_clk = 1'b0;
            wait_clk(HALF);
            ps2_clk = 1'b1;
        end
        wait_clk(HALF);
        ps2_data = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                         input int glitch_bit);
        if (bad_par || bad_stop) model_err();
        else                     model_good(b);
        send_bits(b, bad_par, bad_stop, 11, glitch_bit);
        wait_drain();
    endtask

    task automatic good(input logic [7:0] b);
        frame(b, 0, 0, -1);
    endtask

    always @(negedge clk) begin
        if (!reset && (scan_valid || frame_err || left || right || down || ro)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {26'd0, scan_valid, frame_err, left, right, down, ro}, 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("frame_err", frame_err, e.is_err);
                chk("scan_valid", scan_valid, !e.is_err);
                chk("scan_code", scan_code, e.code);
                chk("cmd", {left, right, down, ro}, e.cmd);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        logic [7:0] ar [4];
        logic [7:0] b;
        ar[0] = 8'h6B; ar[1] = 8'h74; ar[2] = 8'h72; ar[3] = 8'h75;

        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        wait_clk(5);
        chk("rst_outs", {26'd0, scan_valid, frame_err, left, right, down, ro}, 0);
        chk("rst_code", scan_code, 0);
        reset = 1'b0;
        wait_clk(20);

        good(8'hE0); good(8'h6B);
        good(8'hE0); good(8'h74);
        good(8'hE0); good(8'h72);
        good(8'hE0); good(8'h75);

        good(8'hE0); good(8'hF0); good(8'h6B);
        good(8'h6B);

        good(8'hE0); frame(8'h6B, 1, 0, -1);
        good(8'hE0); good(8'h6B);
        good(8'hE0); frame(8'h74, 0, 1, -1);
        good(8'h74);

        // Timeout mid-frame after an E0 prefix: prefix must be forgotten.
        good(8'hE0);
        model_err();
        send_bits(8'h33, 0, 0, 5, -1);
        wait_clk(TO + 100);
        wait_drain();
        good(8'h75);
        good(8'hE0); good(8'h75);

        frame(8'hE0, 0, 0, 3);
        frame(8'h72, 0, 0, 7);

        // Reset part way through a frame, then a fresh frame pair.
        good(8'hE0);
        send_bits(8'h74, 0, 0, 4, -1);
        reset = 1'b1;
        #1;
        chk("midrst_outs", {26'd0, scan_valid, frame_err, left, right, down, ro}, 0);
        chk("midrst_code", scan_code, 0);
        pend_q.delete(); exp_q.delete(); last_code = 8'h00;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(30);
        good(8'hE0); good(8'h74);

        for (int n = 0; n < 20; n++) begin
            b = 8'($urandom);
            case ($urandom_range(0, 5))
                0: begin good(8'hE0); good(ar[$urandom_range(0, 3)]); end
                1: begin good(8'hE0); good(8'hF0); good(ar[$urandom_range(0, 3)]); end
                2: good(b);
                3: begin good(8'hE0); frame(ar[$urandom_range(0, 3)], 1, 0, -1); end
                4: frame(b, 0, 0, $urandom_range(1, 9));
                default: begin good(8'hE0); frame(ar[$urandom_range(0, 3)], 0, 1, -1); end
            endcase
        end

        wait_clk(50);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
